// File: rtl/sram_burst_if.sv
// Requester-side bus of the SRAM burst controller: word requests in, line data and handshake out.
interface sram_burst_if #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BURST_WORDS = 2
);
    logic                          wr_en;
    logic                          rd_en;
    logic [ADDR_W-1:0]             addr;
    logic [WORD_W-1:0]             wdata;
    logic [WORD_W*BURST_WORDS-1:0] rdata;
    logic                          ready;
    logic                          busy;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, ready, busy
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, ready, busy
    );
endinterface

// File: rtl/sram_burst_controller.sv
// Bridges word writes and aligned burst reads onto a 16-bit asynchronous SRAM with programmable wait states.
module sram_burst_controller #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned SRAM_DATA_W = 16,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned BURST_WORDS = 2,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_burst_if.slave            bus,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);
    localparam int unsigned RD_BEATS = 2 * BURST_WORDS;
    localparam int unsigned WR_BEATS = 2;
    localparam int unsigned BEAT_W   = $clog2(RD_BEATS);
    localparam int unsigned CYC_W    = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned LINE_W   = WORD_W * BURST_WORDS;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    op_wr_q, op_wr_d;
    logic [SRAM_ADDR_W-1:0]  base_q, base_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic [SRAM_ADDR_W-1:0]  addr_q, addr_d;
    logic                    we_n_q, we_n_d;
    logic                    dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_W-1:0]  dq_out_q, dq_out_d;

    logic [ADDR_W-1:0]       off;
    logic [ADDR_W-1:0]       wi;
    logic [ADDR_W-1:0]       wi_line;
    logic                    beat_end;
    logic                    last_beat;

    // Byte address -> word index; reads start at the burst-aligned word.
    always_comb begin
        off     = bus.addr - ADDR_W'(BASE_ADDR);
        wi      = off >> 2;
        wi_line = wi & ~ADDR_W'(BURST_WORDS - 1);
    end

    assign beat_end  = (cyc_q == CYC_W'(WAIT_CYCLES));
    assign last_beat = op_wr_q ? (beat_q == BEAT_W'(WR_BEATS - 1))
                               : (beat_q == BEAT_W'(RD_BEATS - 1));

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.wr_en || bus.rd_en) begin
                    state_d = ACCESS;
                    op_wr_d = bus.wr_en;
                    base_d  = bus.wr_en ? SRAM_ADDR_W'({wi, 1'b0})
                                        : SRAM_ADDR_W'({wi_line, 1'b0});
                    wdata_d = bus.wdata;
                    beat_d  = '0;
                    cyc_d   = '0;
                end
            end
            ACCESS: begin
                if (beat_end) begin
                    if (!op_wr_q) begin
                        for (int unsigned k = 0; k < RD_BEATS; k++) begin
                            if (beat_q == BEAT_W'(k)) begin
                                rdata_d[k*SRAM_DATA_W +: SRAM_DATA_W] = SRAM_DQ;
                            end
                        end
                    end
                    cyc_d = '0;
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values are computed from the next state so they change on the same edge as the FSM.
        ready_d  = (state_d == DONE);
        busy_d   = (state_d != IDLE);
        addr_d   = addr_q;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = dq_out_q;
        if (state_d == ACCESS) begin
            addr_d   = base_d + SRAM_ADDR_W'(beat_d);
            dq_oe_d  = op_wr_d;
            we_n_d   = !(op_wr_d && (cyc_d != CYC_W'(WAIT_CYCLES)));
            dq_out_d = beat_d[0] ? wdata_d[WORD_W-1:SRAM_DATA_W]
                                 : wdata_d[SRAM_DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_wr_q  <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            beat_q   <= '0;
            cyc_q    <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            we_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_wr_q  <= op_wr_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            beat_q   <= beat_d;
            cyc_q    <= cyc_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench: default-parameter controller (WAIT=1, BURST=2) plus a WAIT=3, BURST=4 instance, each with an SRAM model.
module tb_sram_burst_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_burst_if #(.ADDR_W(32), .WORD_W(32), .BURST_WORDS(2)) if_a ();
    sram_burst_if #(.ADDR_W(32), .WORD_W(32), .BURST_WORDS(4)) if_b ();

    logic [17:0] sram_addr_a, sram_addr_b;
    wire  [15:0] dq_a, dq_b;
    logic        we_n_a, ub_a, lb_a, ce_a, oe_a;
    logic        we_n_b, ub_b, lb_b, ce_b, oe_b;

    sram_burst_controller #(.WAIT_CYCLES(1), .BURST_WORDS(2)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a),
        .SRAM_ADDR(sram_addr_a), .SRAM_DQ(dq_a), .SRAM_WE_N(we_n_a),
        .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
    );

    sram_burst_controller #(.WAIT_CYCLES(3), .BURST_WORDS(4)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b),
        .SRAM_ADDR(sram_addr_b), .SRAM_DQ(dq_b), .SRAM_WE_N(we_n_b),
        .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
    );

    // SRAM models: read contents are preloaded; writes are logged per WE_N-low cycle.
    logic [15:0] rom_a [0:63];
    logic [15:0] rom_b [0:63];
    logic        rd_drv_a = 1'b0;
    logic        rd_drv_b = 1'b0;
    assign dq_a = rd_drv_a ? rom_a[sram_addr_a[5:0]] : 16'hzzzz;
    assign dq_b = rd_drv_b ? rom_b[sram_addr_b[5:0]] : 16'hzzzz;

    logic [17:0] log_addr [0:63];
    logic [15:0] log_data [0:63];
    int          log_n     = 0;
    int          rdy_cnt_a = 0;

    always @(posedge clk) begin
        if (!reset && !we_n_a) begin
            log_addr[log_n[5:0]] <= sram_addr_a;
            log_data[log_n[5:0]] <= dq_a;
            log_n                <= log_n + 1;
        end
        if (if_a.ready) rdy_cnt_a <= rdy_cnt_a + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request on A; lat counts edges from the sample edge up to the one that raises ready.
    task automatic req_a(input logic wr, input logic rd, input logic [31:0] ad,
                         input logic [31:0] wd, output int lat);
        if_a.wr_en = wr; if_a.rd_en = rd; if_a.addr = ad; if_a.wdata = wd;
        rd_drv_a   = rd & ~wr;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!if_a.ready && lat < 200);
        if_a.wr_en = 1'b0; if_a.rd_en = 1'b0; rd_drv_a = 1'b0;
    endtask

    task automatic req_b(input logic [31:0] ad, output int lat);
        if_b.wr_en = 1'b0; if_b.rd_en = 1'b1; if_b.addr = ad; if_b.wdata = '0;
        rd_drv_b   = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!if_b.ready && lat < 200);
        if_b.rd_en = 1'b0; rd_drv_b = 1'b0;
    endtask

    function automatic logic [33:0] log_at(input int i);
        logic [5:0] idx;
        idx = i[5:0];
        return {log_addr[idx], log_data[idx]};
    endfunction

    initial begin
        int lat, lat2, n0, rc;
        if_a.wr_en = 1'b0; if_a.rd_en = 1'b0; if_a.addr = '0; if_a.wdata = '0;
        if_b.wr_en = 1'b0; if_b.rd_en = 1'b0; if_b.addr = '0; if_b.wdata = '0;
        for (int i = 0; i < 64; i++) begin
            rom_a[i] = 16'h0;
            rom_b[i] = 16'h1000 + 16'(i);
        end
        rom_a[0] = 16'hBEEF; rom_a[1] = 16'hDEAD; rom_a[2] = 16'h5678; rom_a[3] = 16'h1234;
        rom_a[4] = 16'h2222; rom_a[5] = 16'h1111; rom_a[6] = 16'h4444; rom_a[7] = 16'h3333;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", if_a.ready, 1'b0);
        check("rst_busy", if_a.busy, 1'b0);
        check("rst_rdata", if_a.rdata, '0);
        check("rst_we_n", we_n_a, 1'b1);
        check("rst_addr", sram_addr_a, '0);
        check("tied_pins", {ub_a, lb_a, ce_a, oe_a, ub_b, lb_b, ce_b, oe_b}, '0);
        check("rst_b_busy_rdata", {if_b.busy, if_b.rdata}, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-word write: low half then high half, one WE_N-low cycle per beat.
        n0 = log_n;
        req_a(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat);
        check("wr_latency", lat, 5);
        check("wr_we_cycles", log_n - n0, 2);
        check("wr_hw0", log_at(n0), {18'd0, 16'hBEEF});
        check("wr_hw1", log_at(n0 + 1), {18'd1, 16'hDEAD});
        @(posedge clk); #1;
        check("wr_after_ready_busy", {if_a.ready, if_a.busy}, 2'b00);

        req_a(1'b0, 1'b1, 32'd1036, 32'h0, lat);
        check("rd_latency", lat, 9);
        check("rd_line", if_a.rdata, 64'h33334444_11112222);
        @(posedge clk); #1;

        // Simultaneous write and read: write wins, line buffer untouched.
        n0 = log_n;
        req_a(1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, lat);
        check("both_latency", lat, 5);
        check("both_we_cycles", log_n - n0, 2);
        check("both_hw0", log_at(n0), {18'd8, 16'hA5A5});
        check("both_hw1", log_at(n0 + 1), {18'd9, 16'hA5A5});
        check("both_rdata_kept", if_a.rdata, 64'h33334444_11112222);
        @(posedge clk); #1;

        // Address past the SRAM range wraps modulo 2^18 halfwords.
        n0 = log_n;
        req_a(1'b1, 1'b0, 32'h0008_0408, 32'h0BADF00D, lat);
        check("wrap_latency", lat, 5);
        check("wrap_hw0", log_at(n0), {18'd4, 16'hF00D});
        check("wrap_hw1", log_at(n0 + 1), {18'd5, 16'h0BAD});
        @(posedge clk); #1;

        // Reset during the third beat of a read.
        if_a.rd_en = 1'b1; if_a.addr = 32'd1032; rd_drv_a = 1'b1;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        check("abort_busy_mid", if_a.busy, 1'b1);
        reset = 1'b1; if_a.rd_en = 1'b0; rd_drv_a = 1'b0;
        rc = rdy_cnt_a;
        @(posedge clk); #1;
        check("abort_busy", if_a.busy, 1'b0);
        check("abort_ready", if_a.ready, 1'b0);
        check("abort_rdata", if_a.rdata, '0);
        check("abort_we_n", we_n_a, 1'b1);
        check("abort_addr", sram_addr_a, '0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_ready", rdy_cnt_a - rc, 0);
        req_a(1'b0, 1'b1, 32'd1024, 32'h0, lat);
        check("post_abort_latency", lat, 9);
        check("post_abort_line", if_a.rdata, 64'h12345678_DEADBEEF);
        @(posedge clk); #1;

        // Back-to-back: read requested in the write's ready cycle.
        rc = rdy_cnt_a;
        n0 = log_n;
        req_a(1'b1, 1'b0, 32'd1044, 32'hCAFEF00D, lat);
        req_a(1'b0, 1'b1, 32'd1032, 32'h0, lat2);
        @(posedge clk); #1;
        check("b2b_wr_latency", lat, 5);
        check("b2b_rd_latency", lat2, 10);
        check("b2b_ready_pulses", rdy_cnt_a - rc, 2);
        check("b2b_hw0", log_at(n0), {18'd10, 16'hF00D});
        check("b2b_hw1", log_at(n0 + 1), {18'd11, 16'hCAFE});
        check("b2b_line", if_a.rdata, 64'h33334444_11112222);
        check("b2b_idle", {if_a.ready, if_a.busy}, 2'b00);

        // WAIT_CYCLES=3, BURST_WORDS=4: eight 4-cycle beats, words ascending.
        req_b(32'd1024, lat);
        check("b_latency", lat, 33);
        check("b_line0", if_b.rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
        @(posedge clk); #1;
        req_b(32'd1052, lat);
        check("b_aligned_latency", lat, 33);
        check("b_aligned_line", if_b.rdata, 128'h100F_100E_100D_100C_100B_100A_1009_1008);
        check("b_we_n", we_n_b, 1'b1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
